// File: rtl/noc_pkg.sv
// Shared router definitions: flit ids, arbiter one-hot states and the
// requester's state encoding.
package noc_pkg;

    localparam int LEN_W = 12;

    localparam logic [2:0] FLIT_NONE   = 3'b000;
    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    localparam logic [5:0] ST_IDLE = 6'b000001;
    localparam logic [5:0] ST_L    = 6'b000010;
    localparam logic [5:0] ST_N    = 6'b000100;
    localparam logic [5:0] ST_E    = 6'b001000;
    localparam logic [5:0] ST_W    = 6'b010000;
    localparam logic [5:0] ST_S    = 6'b100000;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_WAIT = 2'd1,
        REQ_SEND = 2'd2
    } req_state_e;

    // Remaining-flit count never drops below 1 while a packet is open.
    function automatic logic [LEN_W-1:0] dec_sat(input logic [LEN_W-1:0] v);
        return (v > 12'd1) ? v - 12'd1 : 12'd1;
    endfunction

    // Arbiter state that means "this port owns the crossbar".
    function automatic logic [5:0] port_mask(input int grant_bit);
        case (grant_bit)
            1:       return ST_L;
            2:       return ST_N;
            3:       return ST_E;
            4:       return ST_W;
            5:       return ST_S;
            default: return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/port_requester.sv
// Per-input-port requester: holds the header, requests the arbiter and
// forwards the packet while granted, re-requesting after preemption.
//
// state    | meaning
// REQ_IDLE | waiting for a HEADER flit
// REQ_WAIT | header held, req asserted, waiting for grant
// REQ_SEND | granted, forwarding BODY/TAIL flits
module port_requester
    import noc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int GRANT_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_flit_id,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_length,
    input  logic [5:0]        grant_state,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic              out_valid,
    output logic [2:0]        out_flit_id,
    output logic [DATA_W-1:0] out_data,
    output logic              proto_err
);

    localparam logic [5:0] GRANT_MASK = port_mask(GRANT_BIT);

    req_state_e        state;
    req_state_e        state_next;
    logic              granted;
    logic [LEN_W-1:0]  rem;
    logic [DATA_W-1:0] hdr_data;
    logic              hdr_sent;

    logic load_hdr;
    logic emit_hdr;
    logic fwd;
    logic err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= REQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        flit_id    = FLIT_NONE;
        length     = '0;
        in_ready   = 1'b0;
        load_hdr   = 1'b0;
        emit_hdr   = 1'b0;
        fwd        = 1'b0;
        err        = 1'b0;
        case (state)
            REQ_IDLE: begin
                in_ready = rst;
                if (in_valid && in_ready) begin
                    if (in_flit_id == FLIT_HEADER) begin
                        load_hdr   = 1'b1;
                        state_next = REQ_WAIT;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            REQ_WAIT: begin
                req     = 1'b1;
                flit_id = FLIT_HEADER;
                length  = rem;
                if (granted) begin
                    state_next = REQ_SEND;
                    emit_hdr   = !hdr_sent;
                end
            end
            REQ_SEND: begin
                req      = 1'b1;
                in_ready = granted && rst;
                // Losing the grant returns to WAIT so the timer reloads with rem.
                if (!granted) begin
                    state_next = REQ_WAIT;
                end else if (in_valid) begin
                    if (in_flit_id == FLIT_BODY || in_flit_id == FLIT_TAIL) begin
                        fwd = 1'b1;
                        if (in_flit_id == FLIT_TAIL) begin
                            state_next = REQ_IDLE;
                        end
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            default: state_next = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            granted     <= 1'b0;
            rem         <= '0;
            hdr_data    <= '0;
            hdr_sent    <= 1'b0;
            out_valid   <= 1'b0;
            out_flit_id <= FLIT_NONE;
            out_data    <= '0;
            proto_err   <= 1'b0;
        end else begin
            granted   <= |(grant_state & GRANT_MASK);
            out_valid <= emit_hdr | fwd;
            if (load_hdr) begin
                hdr_data <= in_data;
                rem      <= (in_length == '0) ? 12'd1 : in_length;
                hdr_sent <= 1'b0;
            end
            if (emit_hdr) begin
                out_flit_id <= FLIT_HEADER;
                out_data    <= hdr_data;
                rem         <= dec_sat(rem);
                hdr_sent    <= 1'b1;
            end
            if (fwd) begin
                out_flit_id <= in_flit_id;
                out_data    <= in_data;
                rem         <= dec_sat(rem);
            end
            if (err) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_port_requester.sv
// Directed bench for port_requester: per-cycle behavioural model, an
// in-order scoreboard of forwarded flits, and literal spot checks.
module tb_port_requester;
    import noc_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_flit_id;
    logic [31:0] in_data;
    logic [11:0] in_length;
    logic [5:0]  grant_state;
    logic        req;
    logic [2:0]  flit_id;
    logic [11:0] length;
    logic        out_valid;
    logic [2:0]  out_flit_id;
    logic [31:0] out_data;
    logic        proto_err;

    port_requester #(.DATA_W(32), .GRANT_BIT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_flit_id(in_flit_id), .in_data(in_data), .in_length(in_length),
        .grant_state(grant_state),
        .req(req), .flit_id(flit_id), .length(length),
        .out_valid(out_valid), .out_flit_id(out_flit_id), .out_data(out_data),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    bit done       = 1'b0;

    // Expected forwarded flits {id, data}, pushed by the stimulus in order.
    logic [34:0] sb[$];

    // Model: phase 0 = no packet, 1 = waiting for grant, 2 = sending.
    int          m_phase    = 0;
    bit          m_granted  = 1'b0;
    int          m_rem      = 0;
    bit          m_hdr_done = 1'b0;
    bit          m_ov       = 1'b0;
    bit          m_perr     = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit  e_req;
        bit  e_rdy;
        int  e_fid;
        int  e_len;
        bit  acc;
        logic [34:0] e;
        e_req = (m_phase != 0);
        e_fid = (m_phase == 1) ? 1 : 0;
        e_len = (m_phase == 1) ? m_rem : 0;
        e_rdy = rst && (m_phase == 0 || (m_phase == 2 && m_granted));
        chk("req", 32'(req), 32'(e_req));
        chk("flit_id", 32'(flit_id), 32'(e_fid));
        chk("length", 32'(length), 32'(e_len));
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("proto_err", 32'(proto_err), 32'(m_perr));
        if (out_valid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sb_extra: unexpected flit id %0h data %0h", out_flit_id, out_data);
            end else begin
                e = sb.pop_front();
                chk("out_flit_id", 32'(out_flit_id), 32'(e[34:32]));
                chk("out_data", out_data, e[31:0]);
            end
        end
        if (!rst) begin
            m_phase = 0; m_granted = 0; m_rem = 0; m_hdr_done = 0; m_ov = 0; m_perr = 0;
        end else begin
            acc  = in_valid && e_rdy;
            m_ov = 1'b0;
            if (m_phase == 0) begin
                if (acc) begin
                    if (in_flit_id == FLIT_HEADER) begin
                        m_rem      = (in_length == 0) ? 1 : int'(in_length);
                        m_hdr_done = 1'b0;
                        m_phase    = 1;
                    end else begin
                        m_perr = 1'b1;
                    end
                end
            end else if (m_phase == 1) begin
                if (m_granted) begin
                    m_phase = 2;
                    if (!m_hdr_done) begin
                        m_ov       = 1'b1;
                        m_hdr_done = 1'b1;
                        m_rem      = (m_rem > 1) ? m_rem - 1 : 1;
                    end
                end
            end else begin
                if (!m_granted) begin
                    m_phase = 1;
                end else if (acc) begin
                    if (in_flit_id == FLIT_BODY || in_flit_id == FLIT_TAIL) begin
                        m_ov  = 1'b1;
                        m_rem = (m_rem > 1) ? m_rem - 1 : 1;
                        if (in_flit_id == FLIT_TAIL) m_phase = 0;
                    end else begin
                        m_perr = 1'b1;
                    end
                end
            end
            m_granted = grant_state[1];
        end
    endtask

    task automatic send_flit(input logic [2:0] id, input logic [31:0] d,
                             input logic [11:0] len, input bit fwd);
        bit acc;
        int n;
        in_valid   = 1'b1;
        in_flit_id = id;
        in_data    = d;
        in_length  = len;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: flit %0h data %0h not accepted, required within 40 cycles", id, d);
        end else if (fwd) begin
            sb.push_back({id, d});
        end
    endtask

    task automatic wait_hdr_req(input string nm);
        int n;
        n = 0;
        while (flit_id != FLIT_HEADER && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (flit_id != FLIT_HEADER) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: flit_id %0h, required 1 within 20 cycles", nm, flit_id);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stimulus();
        // Basic packet
        send_flit(FLIT_HEADER, 32'hA000_00A0, 12'd4, 1'b1);
        chk("basic_req", 32'(req), 32'd1);
        chk("basic_fid", 32'(flit_id), 32'd1);
        chk("basic_len", 32'(length), 32'd4);
        idle(2);
        grant_state = ST_L;
        send_flit(FLIT_BODY, 32'h0000_00A1, 12'd0, 1'b1);
        send_flit(FLIT_BODY, 32'h0000_00A2, 12'd0, 1'b1);
        send_flit(FLIT_TAIL, 32'h0000_00A3, 12'd0, 1'b1);
        grant_state = ST_IDLE;
        chk("basic_req_drop", 32'(req), 32'd0);
        idle(2);

        // Preemption after header + 1 body
        send_flit(FLIT_HEADER, 32'h0000_00B0, 12'd6, 1'b1);
        grant_state = ST_L;
        send_flit(FLIT_BODY, 32'h0000_00B1, 12'd0, 1'b1);
        grant_state = ST_IDLE;
        wait_hdr_req("pre");
        chk("pre_len", 32'(length), 32'd4);
        chk("pre_req", 32'(req), 32'd1);
        chk("pre_ready", 32'(in_ready), 32'd0);
        idle(2);
        chk("pre_hold_len", 32'(length), 32'd4);
        grant_state = ST_L;
        send_flit(FLIT_BODY, 32'h0000_00B2, 12'd0, 1'b1);
        send_flit(FLIT_BODY, 32'h0000_00B3, 12'd0, 1'b1);
        send_flit(FLIT_BODY, 32'h0000_00B4, 12'd0, 1'b1);
        send_flit(FLIT_TAIL, 32'h0000_00B5, 12'd0, 1'b1);
        grant_state = ST_IDLE;
        idle(2);

        // Protocol errors
        chk("perr_clear", 32'(proto_err), 32'd0);
        send_flit(FLIT_BODY, 32'h0000_00C9, 12'd0, 1'b0);
        chk("perr_idle_body", 32'(proto_err), 32'd1);
        chk("perr_still_idle", 32'(req), 32'd0);
        send_flit(FLIT_HEADER, 32'h0000_00C0, 12'd3, 1'b1);
        grant_state = ST_L;
        send_flit(FLIT_BODY, 32'h0000_00C1, 12'd0, 1'b1);
        send_flit(FLIT_HEADER, 32'h0000_00CE, 12'd7, 1'b0);
        chk("perr_mid_hdr", 32'(proto_err), 32'd1);
        send_flit(FLIT_TAIL, 32'h0000_00C2, 12'd0, 1'b1);
        grant_state = ST_IDLE;
        idle(2);

        // Boundaries: zero length, max length, header+tail only
        send_flit(FLIT_HEADER, 32'h0000_00D0, 12'd0, 1'b1);
        chk("len_zero", 32'(length), 32'd1);
        grant_state = ST_L;
        send_flit(FLIT_TAIL, 32'h0000_00D1, 12'd0, 1'b1);
        grant_state = ST_IDLE;
        idle(2);
        send_flit(FLIT_HEADER, 32'h0000_00E0, 12'hFFF, 1'b1);
        chk("len_max", 32'(length), 32'd4095);
        grant_state = ST_L;
        send_flit(FLIT_TAIL, 32'h0000_00E1, 12'd0, 1'b1);
        grant_state = ST_IDLE;
        idle(2);

        // Reset in the middle of SEND
        send_flit(FLIT_HEADER, 32'h0000_00F0, 12'd5, 1'b1);
        grant_state = ST_L;
        send_flit(FLIT_BODY, 32'h0000_00F1, 12'd0, 1'b1);
        send_flit(FLIT_BODY, 32'h0000_00F2, 12'd0, 1'b1);
        rst = 1'b0;
        grant_state = ST_IDLE;
        @(posedge clk);
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_fid", 32'(flit_id), 32'd0);
        chk("rst_len", 32'(length), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_oid", 32'(out_flit_id), 32'd0);
        chk("rst_odata", out_data, 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        chk("rst_ready_low", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_idle_ready", 32'(in_ready), 32'd1);
        send_flit(FLIT_HEADER, 32'h0000_0090, 12'd2, 1'b1);
        chk("post_rst_len", 32'(length), 32'd2);
        grant_state = ST_L;
        send_flit(FLIT_TAIL, 32'h0000_0091, 12'd0, 1'b1);
        grant_state = ST_IDLE;
        idle(3);
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_flit_id  = 3'b000;
        in_data     = 32'd0;
        in_length   = 12'd0;
        grant_state = ST_IDLE;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", 32'(req), 32'd0);
        chk("reset_fid", 32'(flit_id), 32'd0);
        chk("reset_len", 32'(length), 32'd0);
        chk("reset_ov", 32'(out_valid), 32'd0);
        chk("reset_oid", 32'(out_flit_id), 32'd0);
        chk("reset_odata", out_data, 32'd0);
        chk("reset_perr", 32'(proto_err), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    model_step();
                end
            end
            begin
                stimulus();
                done = 1'b1;
            end
        join
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
